// File: rtl/sc_io_display.sv
// sc_io_display: converts three 8-bit output ports to two decimal digits each via
// iterative double-dabble and drives six active-low seven-segment displays.
module sc_io_display #(
    parameter bit BLANK_LEADING_ZERO = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [23:0] io_out,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic        busy,
    output logic        update
);
    typedef enum logic [1:0] {IDLE, CAPTURE, CONV, COMMIT} state_t;
    state_t      state;
    logic [23:0] snapshot;
    logic [1:0]  field;
    logic [2:0]  step;
    logic [11:0] bcd, adj, nxt;
    logic [35:0] res;
    logic [41:0] segs;
    logic        start;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'b1000000;
            4'd1: seg7 = 7'b1111001;
            4'd2: seg7 = 7'b0100100;
            4'd3: seg7 = 7'b0110000;
            4'd4: seg7 = 7'b0011001;
            4'd5: seg7 = 7'b0010010;
            4'd6: seg7 = 7'b0000010;
            4'd7: seg7 = 7'b1111000;
            4'd8: seg7 = 7'b0000000;
            4'd9: seg7 = 7'b0010000;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Hundreds digit is only an over-range flag: any nonzero value shows dashes.
    function automatic logic [13:0] pair(input logic [11:0] b);
        pair = (b[11:8] != 4'd0) ? {7'h3F, 7'h3F} :
               {(BLANK_LEADING_ZERO && b[7:4] == 4'd0) ? 7'h7F : seg7(b[7:4]), seg7(b[3:0])};
    endfunction

    assign adj = {(bcd[11:8] >= 4'd5) ? bcd[11:8] + 4'd3 : bcd[11:8],
                  (bcd[7:4]  >= 4'd5) ? bcd[7:4]  + 4'd3 : bcd[7:4],
                  (bcd[3:0]  >= 4'd5) ? bcd[3:0]  + 4'd3 : bcd[3:0]};
    // ~step walks the field MSB first
    assign nxt   = {adj[10:0], snapshot[{field, ~step}]};
    assign segs  = {pair(res[35:24]), pair(res[23:12]), pair(res[11:0])};
    assign start = (state == CAPTURE) || (io_out != snapshot);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= CAPTURE;
            snapshot <= '0;
            field    <= '0;
            step     <= '0;
            bcd      <= '0;
            res      <= '0;
            busy     <= 1'b1;
            update   <= 1'b0;
            {hex5, hex4, hex3, hex2, hex1, hex0} <= {6{7'h7F}};
        end else begin
            update <= 1'b0;
            case (state)
                IDLE, CAPTURE: begin
                    busy <= start;
                    if (start) begin
                        snapshot <= io_out;
                        field    <= '0;
                        step     <= '0;
                        bcd      <= '0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    step <= step + 3'd1;
                    if (step == 3'd7) begin
                        res   <= {nxt, res[35:12]};
                        bcd   <= '0;
                        field <= field + 2'd1;
                        if (field == 2'd2) state <= COMMIT;
                    end else begin
                        bcd <= nxt;
                    end
                end
                COMMIT: begin
                    {hex5, hex4, hex3, hex2, hex1, hex0} <= segs;
                    update <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sc_io_display.sv
// tb_sc_io_display: directed stimulus, event-level reference model and literal checks.
module tb_sc_io_display;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] io_out = '0;
    logic [6:0]  ha0, ha1, ha2, ha3, ha4, ha5, hb0, hb1, hb2, hb3, hb4, hb5;
    logic        busy_a, update_a, busy_b, update_b;
    logic [41:0] hex_a, hex_b;
    int          passed = 0, total = 0, pulses = 0;
    bit          started = 1'b0;

    localparam logic [6:0]  DASH  = 7'b0111111;
    localparam logic [6:0]  BLANK = 7'b1111111;
    localparam logic [6:0]  D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100, D3 = 7'b0110000,
                            D4 = 7'b0011001, D5 = 7'b0010010, D6 = 7'b0000010, D7 = 7'b1111000,
                            D8 = 7'b0000000, D9 = 7'b0010000;
    localparam logic [69:0] SEG = {D9, D8, D7, D6, D5, D4, D3, D2, D1, D0};

    sc_io_display #(.BLANK_LEADING_ZERO(1'b0)) dut_a (
        .clock(clock), .reset(reset), .io_out(io_out),
        .hex0(ha0), .hex1(ha1), .hex2(ha2), .hex3(ha3), .hex4(ha4), .hex5(ha5),
        .busy(busy_a), .update(update_a));
    sc_io_display #(.BLANK_LEADING_ZERO(1'b1)) dut_b (
        .clock(clock), .reset(reset), .io_out(io_out),
        .hex0(hb0), .hex1(hb1), .hex2(hb2), .hex3(hb3), .hex4(hb4), .hex5(hb5),
        .busy(busy_b), .update(update_b));

    assign hex_a = {ha5, ha4, ha3, ha2, ha1, ha0};
    assign hex_b = {hb5, hb4, hb3, hb2, hb1, hb0};

    always #5 clock = ~clock;

    function automatic logic [41:0] disp(input logic [23:0] v, input bit blz);
        logic [41:0] r;
        int f, t, o;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            f = int'(v[8*k +: 8]);
            t = f / 10;
            o = f % 10;
            if (f > 99) r[14*k +: 14] = {DASH, DASH};
            else r[14*k +: 14] = {(blz && t == 0) ? BLANK : SEG[7*t +: 7], SEG[7*o +: 7]};
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Event-level model: a detected change commits its display 25 edges later.
    logic [41:0] m_hex_a, m_hex_b;
    logic [23:0] m_snap, m_conv;
    logic        m_busy, m_update, m_capture;
    int          m_cnt;

    always @(posedge clock) begin
        started <= 1'b1;
        if (update_a) pulses <= pulses + 1;
        if (reset) begin
            m_hex_a   <= {6{BLANK}};
            m_hex_b   <= {6{BLANK}};
            m_busy    <= 1'b1;
            m_update  <= 1'b0;
            m_cnt     <= -1;
            m_capture <= 1'b1;
            m_snap    <= '0;
        end else begin
            m_update <= 1'b0;
            if (m_cnt == 0) begin
                m_hex_a  <= disp(m_conv, 1'b0);
                m_hex_b  <= disp(m_conv, 1'b1);
                m_update <= 1'b1;
                m_busy   <= 1'b1;
                m_cnt    <= -1;
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
            end else if (m_capture || io_out != m_snap) begin
                m_snap    <= io_out;
                m_conv    <= io_out;
                m_cnt     <= 24;
                m_busy    <= 1'b1;
                m_capture <= 1'b0;
            end else begin
                m_busy <= 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            chk("model_hex_a", 64'(hex_a), 64'(m_hex_a));
            chk("model_hex_b", 64'(hex_b), 64'(m_hex_b));
            chk("model_busy", {busy_b, busy_a}, {m_busy, m_busy});
            chk("model_update", {update_b, update_a}, {m_update, m_update});
        end
    end

    initial begin
        tick(3);
        chk("reset_hex", 64'(hex_a), 64'({6{7'h7F}}));
        chk("reset_busy", busy_a, 1'b1);
        chk("reset_update", update_a, 1'b0);
        reset = 1'b0;
        pulses = 0;
        tick(12);
        chk("post_reset_busy_mid", busy_a, 1'b1);
        tick(14);
        chk("post_reset_hex", 64'(hex_a), 64'({6{D0}}));
        chk("post_reset_update", update_a, 1'b1);
        tick(2);
        chk("post_reset_busy_low", busy_a, 1'b0);
        chk("post_reset_pulses", pulses, 1);

        io_out = {8'd99, 8'd42, 8'd7};
        pulses = 0;
        tick(25);
        chk("no_early_update", update_a, 1'b0);
        tick(1);
        chk("hex_99_42_07", 64'(hex_a), 64'({D9, D9, D4, D2, D0, D7}));
        tick(2);
        chk("pulses_99_42_07", pulses, 1);

        io_out = {8'd255, 8'd100, 8'd0};
        tick(26);
        chk("hex_overrange", 64'(hex_a), 64'({DASH, DASH, DASH, DASH, D0, D0}));
        tick(2);

        io_out = 24'd5;
        pulses = 0;
        tick(11);
        io_out = 24'd12;
        tick(15);
        chk("hex_first_05", 64'(hex_a), 64'({D0, D0, D0, D0, D0, D5}));
        tick(26);
        chk("hex_second_12", 64'(hex_a), 64'({D0, D0, D0, D0, D1, D2}));
        tick(2);
        chk("pulses_busy_change", pulses, 2);

        io_out = {8'd99, 8'd42, 8'd7};
        tick(16);
        reset = 1'b1;
        tick(1);
        chk("abort_hex", 64'(hex_a), 64'({6{7'h7F}}));
        chk("abort_update", update_a, 1'b0);
        reset = 1'b0;
        pulses = 0;
        tick(26);
        chk("abort_recovery_hex", 64'(hex_a), 64'({D9, D9, D4, D2, D0, D7}));
        tick(2);
        chk("abort_recovery_pulses", pulses, 1);

        io_out = {8'd0, 8'd9, 8'd10};
        tick(26);
        chk("blz_hex", 64'(hex_b), 64'({BLANK, D0, BLANK, D9, D1, D0}));
        chk("noblz_hex", 64'(hex_a), 64'({D0, D0, D0, D9, D1, D0}));
        tick(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
